// File: rtl/arps_mv_drain.sv
// rtl/arps_mv_drain.sv - drains ARPS motion-vector BRAM onto a valid/ready stream with tlast and done pulse
// Optional feature macro: ARPS_MV_STATS_EN adds nonzero_cnt_o (saturating count of non-zero MVs).
module arps_mv_drain #(
  parameter int          NUM_MV     = 396,
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter logic [31:0] ADDR_STEP  = 32'd4,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic [31:0]           addr_mv_o,
  output logic                  en_mv_o,
  output logic [3:0]            we_mv_o,
  input  logic [DATA_WIDTH-1:0] data_mv_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef ARPS_MV_STATS_EN
  ,
  output logic [15:0]           nonzero_cnt_o
`endif
);

  localparam int IW = $clog2(NUM_MV + 1);
  localparam logic [IW-1:0] LP_LAST = IW'(NUM_MV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [IW-1:0]         r_rd_idx;
  logic [IW-1:0]         r_out_idx;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [0:1];
  logic                  r_head;
  logic [1:0]            r_count;

  logic w_pop;
  logic w_issue;
  logic w_start;
  logic w_tail;

  assign w_pop   = m_tvalid_o & m_tready_i;
  assign w_start = (r_state == S_IDLE) & start_i;
  assign w_tail  = r_head ^ r_count[0];
  // Occupancy counts the word still in BRAM flight; the same-cycle pop frees a slot.
  assign w_issue = (r_state == S_READ) &&
                   (({1'b0, r_count} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));

  assign en_mv_o    = w_issue;
  assign addr_mv_o  = BASE_ADDR + 32'(r_rd_idx) * ADDR_STEP;
  assign we_mv_o    = 4'b0000;
  assign m_tdata_o  = r_buf[r_head];
  assign m_tvalid_o = (r_count != 2'd0);
  assign m_tlast_o  = m_tvalid_o && (r_out_idx == LP_LAST);
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rd_idx   <= '0;
      r_out_idx  <= '0;
      r_inflight <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE:  if (start_i) r_state <= S_READ;
        S_READ:  if (w_issue && (r_rd_idx == LP_LAST)) r_state <= S_DRAIN;
        S_DRAIN: if (w_pop && (r_out_idx == LP_LAST)) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase

      r_inflight <= w_issue;
      if (r_inflight) r_buf[w_tail] <= data_mv_i;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_issue) r_rd_idx <= r_rd_idx + 1'b1;
      if (w_pop) begin
        r_out_idx <= r_out_idx + 1'b1;
        r_head    <= ~r_head;
      end

      if (w_start) begin
        r_rd_idx   <= '0;
        r_out_idx  <= '0;
        r_inflight <= 1'b0;
        r_head     <= 1'b0;
        r_count    <= 2'd0;
      end
    end
  end

`ifdef ARPS_MV_STATS_EN
  logic [15:0] r_nz_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nz_cnt <= 16'd0;
    end else if (w_start) begin
      r_nz_cnt <= 16'd0;
    end else if (w_pop && (m_tdata_o[15:0] != 16'd0) && (r_nz_cnt != 16'hFFFF)) begin
      r_nz_cnt <= r_nz_cnt + 16'd1;
    end
  end

  assign nonzero_cnt_o = r_nz_cnt;
`endif

endmodule

// File: tb/tb_arps_mv_drain.sv
// tb/tb_arps_mv_drain.sv - randomized self-checking bench for arps_mv_drain against an ordered-frame reference
module tb_arps_mv_drain;

  localparam int NUM = 396;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] addr_mv_o;
  logic        en_mv_o;
  logic [3:0]  we_mv_o;
  logic [31:0] data_mv_i = '0;
  logic [31:0] m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tready_i = 1'b0;
  logic        m_tlast_o;
  logic        busy_o;
  logic        done_o;
`ifdef ARPS_MV_STATS_EN
  logic [15:0] nonzero_cnt_o;
  logic [15:0] nonzero_cnt1;
`endif

  logic        start1 = 1'b0;
  logic [31:0] addr1;
  logic        en1;
  logic [3:0]  we1;
  logic [31:0] data1 = '0;
  logic [31:0] td1;
  logic        tv1;
  logic        tready1 = 1'b1;
  logic        tl1;
  logic        busy1;
  logic        done1;
  logic [31:0] word1 = '0;

  arps_mv_drain #(.NUM_MV(NUM)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .addr_mv_o(addr_mv_o), .en_mv_o(en_mv_o), .we_mv_o(we_mv_o), .data_mv_i(data_mv_i),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
    .busy_o(busy_o), .done_o(done_o)
`ifdef ARPS_MV_STATS_EN
    , .nonzero_cnt_o(nonzero_cnt_o)
`endif
  );

  arps_mv_drain #(.NUM_MV(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1),
    .addr_mv_o(addr1), .en_mv_o(en1), .we_mv_o(we1), .data_mv_i(data1),
    .m_tdata_o(td1), .m_tvalid_o(tv1), .m_tready_i(tready1), .m_tlast_o(tl1),
    .busy_o(busy1), .done_o(done1)
`ifdef ARPS_MV_STATS_EN
    , .nonzero_cnt_o(nonzero_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:NUM-1];
  always @(posedge clk) begin
    if (en_mv_o) data_mv_i <= mem[addr_mv_o[10:2]];
    if (en1) data1 <= word1;
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] q_got[$];
  int          done_cyc_q[$];
  int n_issued, n_popped, tlast_cnt, tlast_bad, stall_bad, outst_bad, addr_bad;
  int first_en_cyc, first_val_cyc;
  logic        prev_stall;
  logic [31:0] prev_data;

  // Observer: records beats and protocol violations; the tests judge the records.
  always @(negedge clk) begin
    if (rst) begin
      if (en_mv_o) begin
        if (addr_mv_o !== 32'((n_issued % NUM) * 4)) addr_bad++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        n_issued++;
      end
      if (prev_stall && (m_tvalid_o !== 1'b1 || m_tdata_o !== prev_data)) stall_bad++;
      if (m_tvalid_o && first_val_cyc < 0) first_val_cyc = cyc;
      if (m_tvalid_o && m_tready_i) begin
        if (m_tlast_o) tlast_cnt++;
        if (m_tlast_o !== ((n_popped % NUM) == NUM - 1)) tlast_bad++;
        q_got.push_back(m_tdata_o);
        n_popped++;
      end
      if (n_issued - n_popped > 2) outst_bad++;
      prev_stall = m_tvalid_o && !m_tready_i;
      prev_data  = m_tdata_o;
      if (done_o) done_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_mon();
    q_got.delete();
    done_cyc_q.delete();
    n_issued = 0; n_popped = 0; tlast_cnt = 0; tlast_bad = 0;
    stall_bad = 0; outst_bad = 0; addr_bad = 0;
    first_en_cyc = -1; first_val_cyc = -1;
    prev_stall = 1'b0; prev_data = '0;
  endtask

  function automatic int seq_errors(input int base);
    int e = 0;
    for (int k = 0; k < NUM; k++)
      if (base + k >= q_got.size() || q_got[base + k] !== mem[k]) e++;
    return e;
  endfunction

  task automatic pulse_start(output int t);
    @(posedge clk); #1;
    start_i = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input bit rnd, input int n_done, input int budget, output bit ok);
    for (int c = 0; c < budget && done_cyc_q.size() < n_done; c++) begin
      @(posedge clk); #1;
      m_tready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    ok = (done_cyc_q.size() >= n_done);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++; if (addr_mv_o !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr_mv_o); end
    n_checks++; if (en_mv_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", en_mv_o); end
    n_checks++; if (we_mv_o !== 4'b0000) begin n_fail++; $display("FAIL reset_we: got %b expected 0000", we_mv_o); end
    n_checks++; if (m_tdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 0", m_tdata_o); end
    n_checks++; if (m_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid_o); end
    n_checks++; if (m_tlast_o !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", m_tlast_o); end
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", busy_o, done_o); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_full_stream();
    int t; bit ok; int d;
    for (int k = 0; k < NUM; k++) mem[k] = 32'(k);
    m_tready_i = 1'b1;
    clear_mon();
    pulse_start(t);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", busy_o); end
    run_until_done(1'b0, 1, 1000, ok);
    d = (done_cyc_q.size() > 0) ? done_cyc_q[0] - t : -1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout: got no done expected done"); end
    n_checks++; if (q_got.size() !== NUM) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", q_got.size(), NUM); end
    n_checks++; if (seq_errors(0) !== 0) begin n_fail++; $display("FAIL full_seq: got %0d bad words expected 0", seq_errors(0)); end
    n_checks++; if (tlast_cnt !== 1 || tlast_bad !== 0) begin n_fail++; $display("FAIL full_tlast: got cnt %0d bad %0d expected 1/0", tlast_cnt, tlast_bad); end
    n_checks++; if (addr_bad !== 0 || n_issued !== NUM) begin n_fail++; $display("FAIL full_addr: got bad %0d reads %0d expected 0/%0d", addr_bad, n_issued, NUM); end
    n_checks++; if (first_en_cyc - t !== 1) begin n_fail++; $display("FAIL full_en_lat: got %0d expected 1", first_en_cyc - t); end
    n_checks++; if (first_val_cyc - t !== 3) begin n_fail++; $display("FAIL full_valid_lat: got %0d expected 3", first_val_cyc - t); end
    n_checks++; if (d !== NUM + 3) begin n_fail++; $display("FAIL full_done_lat: got %0d expected %0d", d, NUM + 3); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (busy_o !== 1'b0 || done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL full_after: got busy %b dones %0d expected 0/1", busy_o, done_cyc_q.size()); end
  endtask

  task automatic test_random_ready();
    int t; bit ok;
    for (int k = 0; k < NUM; k++) mem[k] = $urandom;
    m_tready_i = 1'b0;
    clear_mon();
    pulse_start(t);
    run_until_done(1'b1, 1, 5000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_timeout: got no done expected done"); end
    n_checks++; if (q_got.size() !== NUM) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", q_got.size(), NUM); end
    n_checks++; if (seq_errors(0) !== 0) begin n_fail++; $display("FAIL rnd_seq: got %0d bad words expected 0", seq_errors(0)); end
    n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL rnd_stable: got %0d unstable stalls expected 0", stall_bad); end
    n_checks++; if (outst_bad !== 0) begin n_fail++; $display("FAIL rnd_outstanding: got %0d over-issues expected 0", outst_bad); end
    n_checks++; if (addr_bad !== 0 || tlast_bad !== 0 || tlast_cnt !== 1) begin n_fail++; $display("FAIL rnd_addr_tlast: got addr_bad %0d tlast_bad %0d tlast %0d expected 0/0/1", addr_bad, tlast_bad, tlast_cnt); end
  endtask

  task automatic test_stall_start();
    int t; bit ok;
    for (int k = 0; k < NUM; k++) mem[k] = 32'(k);
    m_tready_i = 1'b0;
    clear_mon();
    pulse_start(t);
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (n_issued !== 2 || addr_bad !== 0) begin n_fail++; $display("FAIL stall_reads: got %0d reads addr_bad %0d expected 2/0", n_issued, addr_bad); end
    n_checks++; if (m_tvalid_o !== 1'b1 || m_tdata_o !== 32'd0) begin n_fail++; $display("FAIL stall_head: got v=%b d=%h expected v=1 d=0", m_tvalid_o, m_tdata_o); end
    run_until_done(1'b0, 1, 1000, ok);
    n_checks++; if (!ok || q_got.size() !== NUM) begin n_fail++; $display("FAIL stall_resume_count: got %0d expected %0d", q_got.size(), NUM); end
    n_checks++; if (seq_errors(0) !== 0) begin n_fail++; $display("FAIL stall_resume_seq: got %0d bad words expected 0", seq_errors(0)); end
  endtask

  task automatic test_back_to_back();
    int t;
    for (int k = 0; k < NUM; k++) mem[k] = 32'(k) ^ 32'h5A00_0000;
    m_tready_i = 1'b1;
    clear_mon();
    @(posedge clk); #1;
    start_i = 1'b1;
    t = cyc;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      start_i = (cyc == t + 150) || (cyc == t + NUM + 3) || (cyc == t + NUM + 4);
      if (done_cyc_q.size() >= 2 && !start_i) break;
    end
    start_i = 1'b0;
    n_checks++; if (done_cyc_q.size() !== 2) begin n_fail++; $display("FAIL b2b_dones: got %0d expected 2", done_cyc_q.size()); end
    n_checks++; if (done_cyc_q.size() < 1 || done_cyc_q[0] !== t + NUM + 3) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected %0d", (done_cyc_q.size() > 0) ? done_cyc_q[0] - t : -1, NUM + 3); end
    n_checks++; if (done_cyc_q.size() < 2 || done_cyc_q[1] !== t + 2 * NUM + 7) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected %0d", (done_cyc_q.size() > 1) ? done_cyc_q[1] - t : -1, 2 * NUM + 7); end
    n_checks++; if (q_got.size() !== 2 * NUM || seq_errors(0) !== 0 || seq_errors(NUM) !== 0) begin n_fail++; $display("FAIL b2b_seq: got %0d words expected %0d in two ordered frames", q_got.size(), 2 * NUM); end
    n_checks++; if (tlast_cnt !== 2 || tlast_bad !== 0) begin n_fail++; $display("FAIL b2b_tlast: got %0d/%0d expected 2/0", tlast_cnt, tlast_bad); end
  endtask

  task automatic test_reset_mid();
    int t; bit ok; logic v_before;
    for (int k = 0; k < NUM; k++) mem[k] = 32'(k);
    m_tready_i = 1'b1;
    clear_mon();
    pulse_start(t);
    for (int c = 0; c < 1000 && q_got.size() < 100; c++) @(posedge clk);
    #3;
    v_before = m_tvalid_o;
    rst = 1'b0;
    #1;
    n_checks++; if (v_before !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_before: got %b expected 1", v_before); end
    n_checks++; if (m_tvalid_o !== 1'b0 || m_tlast_o !== 1'b0 || m_tdata_o !== 32'd0) begin n_fail++; $display("FAIL rmid_stream: got v=%b l=%b d=%h expected 0/0/0", m_tvalid_o, m_tlast_o, m_tdata_o); end
    n_checks++; if (en_mv_o !== 1'b0 || addr_mv_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl: got en=%b addr=%h busy=%b done=%b expected 0", en_mv_o, addr_mv_o, busy_o, done_o); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    n_checks++; if (done_cyc_q.size() !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d dones expected 0", done_cyc_q.size()); end
    clear_mon();
    pulse_start(t);
    run_until_done(1'b0, 1, 1000, ok);
    n_checks++; if (!ok || q_got.size() !== NUM || q_got[0] !== 32'd0) begin n_fail++; $display("FAIL rmid_restart: got %0d words expected %0d from 0", q_got.size(), NUM); end
    n_checks++; if (seq_errors(0) !== 0) begin n_fail++; $display("FAIL rmid_seq: got %0d bad words expected 0", seq_errors(0)); end
  endtask

  task automatic test_num_mv1();
    int n_en = 0, beats = 0, vcyc = -1, dcyc = -1, a_bad = 0;
    logic [31:0] got = '0;
    logic lastseen = 1'b0;
    word1 = $urandom | 32'h1;
    tready1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (en1) begin n_en++; if (addr1 !== 32'd0) a_bad++; end
      if (tv1) begin beats++; got = td1; lastseen = tl1; vcyc = c; end
      if (done1) dcyc = c;
      if (c == 0) begin @(posedge clk); #1 start1 = 1'b0; end
    end
    n_checks++; if (n_en !== 1 || a_bad !== 0) begin n_fail++; $display("FAIL mv1_reads: got %0d reads addr_bad %0d expected 1/0", n_en, a_bad); end
    n_checks++; if (beats !== 1 || got !== word1 || lastseen !== 1'b1) begin n_fail++; $display("FAIL mv1_beat: got %0d beats d=%h l=%b expected 1 d=%h l=1", beats, got, lastseen, word1); end
    n_checks++; if (vcyc !== 3 || dcyc !== 4) begin n_fail++; $display("FAIL mv1_timing: got valid@%0d done@%0d expected 3/4", vcyc, dcyc); end
  endtask

`ifdef ARPS_MV_STATS_EN
  task automatic test_stats();
    int t; bit ok;
    for (int k = 0; k < NUM; k++) mem[k] = (k % 2 == 1) ? 32'h0000_0102 : 32'h0;
    m_tready_i = 1'b1;
    clear_mon();
    pulse_start(t);
    n_checks++; if (nonzero_cnt_o !== 16'd0) begin n_fail++; $display("FAIL stats_clear: got %0d expected 0", nonzero_cnt_o); end
    run_until_done(1'b1, 1, 5000, ok);
    n_checks++; if (!ok || nonzero_cnt_o !== 16'd198) begin n_fail++; $display("FAIL stats_count: got %0d expected 198", nonzero_cnt_o); end
    repeat (5) @(posedge clk); #1;
    n_checks++; if (nonzero_cnt_o !== 16'd198) begin n_fail++; $display("FAIL stats_hold: got %0d expected 198", nonzero_cnt_o); end
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_full_stream();
    test_random_ready();
    test_stall_start();
    test_back_to_back();
    test_reset_mid();
    test_num_mv1();
`ifdef ARPS_MV_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arps_mv_drain.md
Name: arps_mv_drain

Overview:
- Downstream consumer of the ARPS motion-vector BRAM port.
- After the ARPS core signals completion, it reads every motion-vector word out of MV BRAM in address order and presents the words on a valid/ready stream, with a last-beat marker, for DMA or host collection.
- It contains the BRAM read sequencer, a 2-entry output buffer that absorbs the 1-cycle BRAM read latency, and a completion pulse.

Parameters:
- NUM_MV, 396, number of motion-vector words per frame (22x18 macroblocks, 352x288 frame, 16x16 blocks).
- BASE_ADDR, 0, byte address of the first MV word in MV BRAM.
- ADDR_STEP, 4, byte increment between consecutive MV words.
- DATA_WIDTH, 32, MV word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse: begin draining a frame (driven from ARPS ready rising edge).
- addr_mv_o  out  32  MV BRAM byte address.
- en_mv_o  out  1  MV BRAM enable; high only in cycles that issue a read.
- we_mv_o  out  4  MV BRAM write enable; constant 4'b0000.
- data_mv_i  in  DATA_WIDTH  MV BRAM read data, valid 1 cycle after the en_mv_o cycle.
- m_tdata_o  out  DATA_WIDTH  stream data.
- m_tvalid_o  out  1  stream valid.
- m_tready_i  in  1  stream ready.
- m_tlast_o  out  1  high on beat NUM_MV-1.
- busy_o  out  1  high from the cycle after start_i accepted until done_o.
- done_o  out  1  one-cycle pulse after the last beat handshakes.

Behaviour:
- Clock, reset and control:
  - One clock.
  - Reset is asynchronous and active-low (rst low clears all state immediately).
  - Reset values: addr_mv_o=BASE_ADDR, en_mv_o=0, we_mv_o=0, m_tdata_o=0, m_tvalid_o=0, m_tlast_o=0, busy_o=0, done_o=0, FSM=IDLE, counters=0, buffer empty.
- FSM:
  - IDLE: start_i=1 -> READ; clear rd_idx, out_idx, buffer.
  - READ: issue reads while rd_idx<NUM_MV; when the last read issues -> DRAIN.
  - DRAIN: wait until the beat with out_idx=NUM_MV-1 handshakes -> DONE.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
  - start_i in any state other than IDLE is ignored.
- Read issue rule:
  - A read issues in a cycle when (buf_count + inflight - pop) < 2.
  - inflight is 1 if a read issued in the previous cycle; pop is (m_tvalid_o & m_tready_i).
  - Issue cycle: en_mv_o=1, addr_mv_o=BASE_ADDR+rd_idx*ADDR_STEP (32-bit, wraps mod 2^32), rd_idx increments.
  - The buffer never overflows; data_mv_i is captured unconditionally into the buffer one cycle after issue.
- Stream:
  - Head of buffer drives m_tdata_o; m_tvalid_o = buffer non-empty.
  - Data is held stable while m_tvalid_o=1 and m_tready_i=0.
  - m_tlast_o = m_tvalid_o & (out_idx==NUM_MV-1).
  - out_idx increments on each handshake.
- Latency and throughput:
  - start_i at cycle T -> first en_mv_o at T+1 -> first m_tvalid_o at T+3.
  - Sustained 1 beat/cycle with m_tready_i held high.
  - Total frame: NUM_MV+3 cycles from start to done_o.
- Boundaries:
  - Simultaneous push and pop with buffer full is legal; count is unchanged.
  - NUM_MV=1: one read, one beat with tlast, then done.
  - Back-to-back: start_i in the same cycle as done_o is ignored; start_i one cycle later is accepted.
  - Reset mid-frame discards all buffered and in-flight data; no done_o.

Optional Feature:
- Macro ARPS_MV_STATS_EN.
- Defined:
  - Adds output nonzero_cnt_o (16 bits).
  - Counts handshaked beats whose bits [15:0] are nonzero, i.e. non-zero motion vectors.
  - Cleared on start acceptance and on reset; saturates at 16'hFFFF; holds its value after done_o.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- NUM_MV=396, BRAM word k = k, m_tready_i=1, pulse start_i -> 396 beats with data 0..395 in order; addresses 0,4,...,1580; tlast only on data 395; done_o exactly 399 cycles after start_i.
- Random m_tready_i (50%) -> same 396-word sequence with no drop or duplicate; data stable during stalls; en_mv_o never issues a third outstanding word.
- m_tready_i=0 for 20 cycles after start -> exactly 2 reads issued (addr 0, 4), m_tvalid_o=1 holding data 0; release -> stream resumes with 1,2,...
- rst asserted low at beat 100 with m_tvalid_o=1 -> all outputs at reset values in the same cycle; a new start after reset yields data from 0 again.
- start_i pulsed mid-frame and in the done_o cycle -> ignored; frame count unaffected; start_i one cycle after done_o -> a new frame begins.
- With ARPS_MV_STATS_EN, words alternate 0x0000_0000 / 0x0000_0102 -> nonzero_cnt_o=198 after done_o.
